// File: rtl/bus_source_mux.sv
// Registered bus source selector: direct select or round-robin arbitration
// over NSRC packed sources. Source index 0 means "no source".
module bus_source_mux #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 3,
  parameter int SELW  = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NSRC*WIDTH-1:0] I,
  input  logic [SELW-1:0]       S,
  input  logic                  MODE,
  input  logic [NSRC-1:0]       REQ,
  input  logic                  EN,
  output logic [WIDTH-1:0]      Q,
  output logic                  QV,
  output logic [NSRC-1:0]       GNT,
  output logic [SELW-1:0]       SRC
);

  logic [WIDTH-1:0] q_reg;
  logic             qv_reg;
  logic [NSRC-1:0]  gnt_reg;
  logic [SELW-1:0]  src_reg;
  logic [SELW-1:0]  ptr_reg;

  // Requests rotated so bit j corresponds to source ((ptr + j) mod NSRC) + 1.
  logic [2*NSRC-1:0] req_dbl;
  logic [2*NSRC-1:0] req_shift;
  logic [NSRC-1:0]   req_rot;
  logic [NSRC-1:0]   rr_first;
  logic [SELW:0]     rr_sum  [NSRC];
  logic [SELW-1:0]   rr_cand [NSRC];
  logic [SELW-1:0]   rr_acc  [NSRC+1];
  logic [SELW-1:0]   rr_idx;
  logic              rr_found;

  assign req_dbl   = {REQ, REQ};
  assign req_shift = req_dbl >> ptr_reg;
  assign req_rot   = req_shift[NSRC-1:0];
  assign rr_acc[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_rr
      if (gi == 0) begin : g_head
        assign rr_first[gi] = req_rot[gi];
      end else begin : g_tail
        assign rr_first[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
      end
      assign rr_sum[gi]  = {1'b0, ptr_reg} + (SELW+1)'(gi + 1);
      assign rr_cand[gi] = (rr_sum[gi] > (SELW+1)'(NSRC))
                           ? SELW'(rr_sum[gi] - (SELW+1)'(NSRC))
                           : SELW'(rr_sum[gi]);
      assign rr_acc[gi+1] = rr_acc[gi] | (rr_first[gi] ? rr_cand[gi] : '0);
    end
  endgenerate

  assign rr_idx   = rr_acc[NSRC];
  assign rr_found = |req_rot;

  logic            dir_valid;
  logic [SELW-1:0] sel_idx;
  logic            load;

  assign dir_valid = (S != '0) && ({1'b0, S} <= (SELW+1)'(NSRC));
  assign sel_idx   = MODE ? rr_idx : S;
  assign load      = EN & (MODE ? rr_found : dir_valid);

  // One-hot decode of the chosen index drives both the grant and the data mux.
  logic [NSRC-1:0]  sel_oh;
  logic [WIDTH-1:0] data_acc [NSRC+1];

  assign data_acc[0] = '0;

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_mux
      assign sel_oh[gi]     = (sel_idx == SELW'(gi + 1));
      assign data_acc[gi+1] = data_acc[gi] | ({WIDTH{sel_oh[gi]}} & I[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_reg   <= '0;
      qv_reg  <= 1'b0;
      gnt_reg <= '0;
      src_reg <= '0;
      ptr_reg <= SELW'(NSRC);
    end else begin
      qv_reg  <= load;
      gnt_reg <= load ? sel_oh : '0;
      if (EN) begin
        src_reg <= load ? sel_idx : '0;
      end
      if (load) begin
        q_reg <= data_acc[NSRC];
      end
      if (load && MODE) begin
        ptr_reg <= sel_idx;
      end
    end
  end

  assign Q   = q_reg;
  assign QV  = qv_reg;
  assign GNT = gnt_reg;
  assign SRC = src_reg;

endmodule
